// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / interrupt controller.
package pipe_ctrl_pkg;

  // Interrupt entry sequence states.
  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    FLUSH,
    ACK,
    WAIT
  } int_state_t;

  // Register $0 is hard-wired to zero and can never create a hazard.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Default MDU latencies and counter width.
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int DEF_CNT_W       = 4;

endpackage

// File: rtl/mdu_busy_counter.sv
// Tracks the multi-cycle mult/div unit: loads its latency on a start pulse,
// counts down to zero and pulses MduDone once the operation has finished.
module mdu_busy_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic MduStartE,
  input  logic MduDivE,
  output logic MduBusy,
  output logic MduDone
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] count;
  logic             load;

  // A start is accepted when idle, or when the running op ends this cycle
  // (the new op wins and no done pulse is issued for the overlapped finish).
  assign load    = MduStartE && (count <= CNT_ONE);
  assign MduBusy = (count != '0);

  // Countdown register and registered done pulse.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      MduDone <= 1'b0;
    end else begin
      if (load) begin
        count <= MduDivE ? DIV_LOAD : MULT_LOAD;
      end else if (count != '0) begin
        count <= count - CNT_ONE;
      end
      MduDone <= (count == CNT_ONE) && !load;
    end
  end

  // The D-stage MDU stall makes a start while busy impossible; flag it if seen.
  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (!reset) !(MduStartE && (count > CNT_ONE))
  );

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: load-use and MDU-use hazard detection in D,
// plus the interrupt entry sequence (drain MDU, flush E/M, acknowledge).
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic       UseRsD,
  input  logic       UseRtD,
  input  logic       MduUseD,
  input  logic [4:0] WriteRegE,
  input  logic       MemReadE,
  input  logic       MduStartE,
  input  logic       MduDivE,
  input  logic       IntReq,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic       InterruptFlush,
  output logic       IntAck,
  output logic       MduBusy,
  output logic       MduDone
);

  int_state_t state, state_next;
  logic       load_use;
  logic       mdu_stall;
  logic       hazard;

  mdu_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_mdu_cnt (
    .clk      (clk),
    .reset    (reset),
    .MduStartE(MduStartE),
    .MduDivE  (MduDivE),
    .MduBusy  (MduBusy),
    .MduDone  (MduDone)
  );

  // A load in E feeding a source register read in D must stall one cycle.
  assign load_use  = MemReadE && (WriteRegE != REG_ZERO) &&
                     ((UseRsD && (RsD == WriteRegE)) ||
                      (UseRtD && (RtD == WriteRegE)));
  assign mdu_stall = MduUseD && MduBusy;
  assign hazard    = load_use || mdu_stall;

  // Interrupt state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode; FLUSH overrides DRAIN overrides hazards.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next     = state;
    StallF         = hazard;
    StallD         = hazard;
    FlushE         = hazard;
    InterruptFlush = 1'b0;
    IntAck         = 1'b0;
    unique case (state)
      IDLE: begin
        if (IntReq) begin
          state_next = MduBusy ? DRAIN : FLUSH;
        end
      end
      DRAIN: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
        if (!MduBusy) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        StallF         = 1'b0;
        StallD         = 1'b0;
        FlushE         = 1'b1;
        InterruptFlush = 1'b1;
        state_next     = ACK;
      end
      ACK: begin
        IntAck     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        // Level request must drop before another interrupt can be taken.
        if (!IntReq) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] RsD, RtD, WriteRegE;
  logic       UseRsD, UseRtD, MduUseD, MemReadE, MduStartE, MduDivE, IntReq;
  logic       StallF, StallD, FlushE, InterruptFlush, IntAck, MduBusy, MduDone;
  logic [7:0] em_reg;

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .CNT_W      (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .RsD           (RsD),
    .RtD           (RtD),
    .UseRsD        (UseRsD),
    .UseRtD        (UseRtD),
    .MduUseD       (MduUseD),
    .WriteRegE     (WriteRegE),
    .MemReadE      (MemReadE),
    .MduStartE     (MduStartE),
    .MduDivE       (MduDivE),
    .IntReq        (IntReq),
    .StallF        (StallF),
    .StallD        (StallD),
    .FlushE        (FlushE),
    .InterruptFlush(InterruptFlush),
    .IntAck        (IntAck),
    .MduBusy       (MduBusy),
    .MduDone       (MduDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in E/M pipeline register: loads a fixed payload, cleared by InterruptFlush.
  always @(posedge clk) em_reg <= InterruptFlush ? 8'h00 : 8'hA5;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hazard_inputs();
    RsD = 5'd0; RtD = 5'd0; WriteRegE = 5'd0;
    UseRsD = 1'b0; UseRtD = 1'b0; MemReadE = 1'b0; MduUseD = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int errs;
    reset = 1'b0;
    clear_hazard_inputs();
    MduStartE = 1'b0; MduDivE = 1'b0; IntReq = 1'b0;
    #22;
    reset = 1'b1;
    tick();

    // Reset state
    check("rst_busy", MduBusy, 0);
    check("rst_done", MduDone, 0);
    check("rst_iflush", InterruptFlush, 0);
    check("rst_ack", IntAck, 0);
    check("rst_stallf", StallF, 0);

    // 1: load-use hazard (combinational)
    RsD = 5'd8; UseRsD = 1'b1; WriteRegE = 5'd8; MemReadE = 1'b1; #1;
    check("lu_rs_stallf", StallF, 1);
    check("lu_rs_stalld", StallD, 1);
    check("lu_rs_flushe", FlushE, 1);
    UseRsD = 1'b0; RsD = 5'd3; UseRtD = 1'b1; RtD = 5'd8; #1;
    check("lu_rt_stalld", StallD, 1);
    RtD = 5'd9; #1;
    check("lu_rt_nomatch", StallD, 0);
    RtD = 5'd8; MemReadE = 1'b0; #1;
    check("lu_noload", StallD, 0);
    MemReadE = 1'b1; WriteRegE = 5'd0; RtD = 5'd0; RsD = 5'd0; UseRsD = 1'b1; #1;
    check("lu_r0_stallf", StallF, 0);
    check("lu_r0_stalld", StallD, 0);
    check("lu_r0_flushe", FlushE, 0);
    clear_hazard_inputs();

    // 2: divide busy window with MDU-use stall, then multiply
    tick(); MduStartE = 1'b1; MduDivE = 1'b1; #1;
    check("div_t0_busy", MduBusy, 0);
    tick(); MduStartE = 1'b0; MduDivE = 1'b0; MduUseD = 1'b1; #1;
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("div_busy_t%0d", k), MduBusy, 1);
      check($sformatf("div_stalld_t%0d", k), StallD, 1);
      check($sformatf("div_done_t%0d", k), MduDone, 0);
      tick();
    end
    check("div_busy_t11", MduBusy, 0);
    check("div_done_t11", MduDone, 1);
    check("div_stalld_t11", StallD, 0);
    tick();
    check("div_done_t12", MduDone, 0);
    MduUseD = 1'b0;

    tick(); MduStartE = 1'b1; MduDivE = 1'b0;
    tick(); MduStartE = 1'b0;
    n = 0;
    while (MduBusy && n < 20) begin
      n++;
      tick();
    end
    check("mult_busy_cycles", n, 5);
    check("mult_done", MduDone, 1);

    // 3: interrupt with MDU idle, level held high afterwards
    tick(); IntReq = 1'b1; #1;
    check("int_req_cycle_iflush", InterruptFlush, 0);
    tick();
    check("int_flush", InterruptFlush, 1);
    check("int_flush_flushe", FlushE, 1);
    check("int_flush_stallf", StallF, 0);
    tick();
    check("int_ack", IntAck, 1);
    check("int_ack_iflush", InterruptFlush, 0);
    errs = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (InterruptFlush || IntAck) errs++;
    end
    check("int_no_retake", errs, 0);
    IntReq = 1'b0;
    tick(); tick();

    // 4: interrupt three cycles after a divide start -> drain, then flush
    tick(); MduStartE = 1'b1; MduDivE = 1'b1;
    tick(); MduStartE = 1'b0; MduDivE = 1'b0;
    tick();
    tick(); IntReq = 1'b1; #1;
    check("drain_t3_stallf", StallF, 0);
    tick();
    check("drain_stallf", StallF, 1);
    check("drain_stalld", StallD, 1);
    check("drain_flushe", FlushE, 1);
    check("drain_em_held", em_reg, 8'hA5);
    n = 1; errs = 0;
    while (!InterruptFlush && n < 30) begin
      tick();
      if (!InterruptFlush) begin
        n++;
        if (!StallF || !StallD) errs++;
      end
    end
    check("drain_cycles", n, 8);
    check("drain_stall_held", errs, 0);
    check("drain_flush", InterruptFlush, 1);
    check("drain_flush_stallf", StallF, 0);
    check("drain_flush_busy", MduBusy, 0);
    tick();
    check("drain_em_cleared", em_reg, 8'h00);
    check("drain_ack", IntAck, 1);
    IntReq = 1'b0;
    tick(); tick();

    // 5: asynchronous reset in the middle of DRAIN
    tick(); MduStartE = 1'b1; MduDivE = 1'b1;
    tick(); MduStartE = 1'b0; MduDivE = 1'b0; IntReq = 1'b1;
    tick();
    check("rstd_drain_stallf", StallF, 1);
    #2;
    reset = 1'b0; IntReq = 1'b0; #1;
    check("rstd_stallf", StallF, 0);
    check("rstd_flushe", FlushE, 0);
    check("rstd_busy", MduBusy, 0);
    check("rstd_iflush", InterruptFlush, 0);
    tick(); tick();
    #2 reset = 1'b1;
    errs = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (IntAck || InterruptFlush) errs++;
    end
    check("rstd_no_ack", errs, 0);

    // 6: load-use hazard coincident with FLUSH
    tick(); IntReq = 1'b1;
    tick(); RsD = 5'd8; UseRsD = 1'b1; WriteRegE = 5'd8; MemReadE = 1'b1; #1;
    check("lu_flush_iflush", InterruptFlush, 1);
    check("lu_flush_stallf", StallF, 0);
    check("lu_flush_stalld", StallD, 0);
    check("lu_flush_flushe", FlushE, 1);
    tick();
    check("lu_ack_ack", IntAck, 1);
    check("lu_ack_stallf", StallF, 1);
    IntReq = 1'b0;
    clear_hazard_inputs();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
